// File: rtl/game_io_bank_pkg.sv
// game_io_pkg: shared constants for the game I/O register bank.
//   - word addresses of the processor-visible registers
//   - STATUS bit positions and the winner-code width
//   - status_word(): assembles the STATUS read value
package game_io_pkg;

  localparam int ADDR_W   = 6;
  localparam int WINNER_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_BALL_X     = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_BALL_Y     = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_LIMITS     = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_INIT       = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_SCORE_INC  = 6'h05;
  localparam logic [ADDR_W-1:0] ADDR_GAME_RST   = 6'h06;
  localparam logic [ADDR_W-1:0] ADDR_PAD_BASE   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_SCORE_BASE = 6'h10;

  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_OVR_BIT  = 1;
  localparam int STATUS_WIN_LSB  = 2;

  // Y fields of packed {y, x} read words start at this bit.
  localparam int Y_FIELD_LSB = 16;

  function automatic logic [31:0] status_word(input logic [WINNER_W-1:0] winner,
                                              input logic overrun,
                                              input logic pending);
    logic [31:0] w;
    w = '0;
    w[STATUS_WIN_LSB +: WINNER_W] = winner;
    w[STATUS_OVR_BIT]             = overrun;
    w[STATUS_PEND_BIT]            = pending;
    return w;
  endfunction

endpackage

// File: rtl/game_io_bank_if.sv
// game_io_bank_if: processor register bus for game_io_bank.
//   wren  - write strobe        addr  - word address
//   wdata - write data          rdata - registered read data
// master: processor side; slave: register bank side.
interface game_io_bank_if;
  import game_io_pkg::*;

  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  modport master (output wren, output addr, output wdata, input rdata);
  modport slave  (input wren, input addr, input wdata, output rdata);
endinterface

// File: rtl/game_io_bank_score_counter.sv
// score_counter: one player's score.
//   clock, reset (sync, active-low)
//   clear  - return to zero (has priority over inc)
//   inc    - add one, saturating at all-ones
//   count  - current score
//   at_win - count equals WIN_SCORE
module score_counter #(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] count,
  output logic               at_win
);

  logic [SCORE_W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + SCORE_W'(1);
    end
  end

  assign count  = count_reg;
  assign at_win = (count_reg == SCORE_W'(WIN_SCORE));

endmodule

// File: rtl/game_io_bank.sv
// game_io_bank: frame-synchronous register bank for a paddle game.
//   clock, reset (sync, active-low), screen_end (high during blanking)
//   bus              - processor register bus (slave side)
//   ball_*lim/*init  - ball limits and start position (live inputs)
//   pad_*            - packed paddle bounds, player 0 in the LSBs
//   ball_x, ball_y   - committed ball position for display
//   winner           - 0 none, p+1 when player p won
//   scores           - packed per-player scores
// Bound inputs are sampled once per frame into shadows so the processor
// sees a consistent snapshot; ball position is double buffered.
module game_io_bank
  import game_io_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       screen_end,
  game_io_bank_if.slave              bus,
  input  logic [X_W-1:0]             ball_xlim,
  input  logic [X_W-1:0]             ball_xinit,
  input  logic [Y_W-1:0]             ball_ylim,
  input  logic [Y_W-1:0]             ball_yinit,
  input  logic [NUM_PLAYERS*X_W-1:0] pad_left,
  input  logic [NUM_PLAYERS*X_W-1:0] pad_right,
  input  logic [NUM_PLAYERS*Y_W-1:0] pad_top,
  input  logic [NUM_PLAYERS*Y_W-1:0] pad_bottom,
  output logic [X_W-1:0]             ball_x,
  output logic [Y_W-1:0]             ball_y,
  output logic [WINNER_W-1:0]        winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  logic se_hist_reg, frame_tick_reg, frame_pending_reg, overrun_reg;
  logic [X_W-1:0] xlim_reg, xinit_reg, pend_x_reg, ball_x_reg;
  logic [Y_W-1:0] ylim_reg, yinit_reg, pend_y_reg, ball_y_reg;
  logic [NUM_PLAYERS*X_W-1:0] left_reg, right_reg;
  logic [NUM_PLAYERS*Y_W-1:0] top_reg, bottom_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic [NUM_PLAYERS-1:0] at_win;
  logic [WINNER_W-1:0] winner_code;

  logic wr_status, wr_ball_x, wr_ball_y, wr_score_inc, wr_game_rst, score_inc;
  logic [1:0] inc_idx;
  logic [X_W-1:0] x_clamp;
  logic [Y_W-1:0] y_clamp;

  assign wr_status    = bus.wren && (bus.addr == ADDR_STATUS);
  assign wr_ball_x    = bus.wren && (bus.addr == ADDR_BALL_X);
  assign wr_ball_y    = bus.wren && (bus.addr == ADDR_BALL_Y);
  assign wr_score_inc = bus.wren && (bus.addr == ADDR_SCORE_INC);
  assign wr_game_rst  = bus.wren && (bus.addr == ADDR_GAME_RST);
  assign inc_idx      = bus.wdata[1:0];
  assign score_inc    = wr_score_inc && (winner_code == '0) && (int'(inc_idx) < NUM_PLAYERS);

  // Clamp against the full 32-bit write value so large writes cannot wrap.
  assign x_clamp = (bus.wdata > 32'(xlim_reg)) ? xlim_reg : bus.wdata[X_W-1:0];
  assign y_clamp = (bus.wdata > 32'(ylim_reg)) ? ylim_reg : bus.wdata[Y_W-1:0];

  // Statement order sets priority: a frame tick overrides a STATUS clear,
  // and GAME_RST overrides the frame commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      se_hist_reg       <= 1'b1;  // no tick if screen_end is high out of reset
      frame_tick_reg    <= 1'b0;
      frame_pending_reg <= 1'b0;
      overrun_reg       <= 1'b0;
      xlim_reg <= '0; xinit_reg <= '0; ylim_reg <= '0; yinit_reg <= '0;
      left_reg <= '0; right_reg <= '0; top_reg <= '0; bottom_reg <= '0;
      pend_x_reg <= ball_xinit; ball_x_reg <= ball_xinit;
      pend_y_reg <= ball_yinit; ball_y_reg <= ball_yinit;
      rdata_reg <= '0;
    end else begin
      se_hist_reg    <= screen_end;
      frame_tick_reg <= screen_end & ~se_hist_reg;
      rdata_reg      <= rdata_next;
      if (wr_status && bus.wdata[STATUS_PEND_BIT]) frame_pending_reg <= 1'b0;
      if (wr_status && bus.wdata[STATUS_OVR_BIT])  overrun_reg       <= 1'b0;
      if (wr_ball_x) pend_x_reg <= x_clamp;
      if (wr_ball_y) pend_y_reg <= y_clamp;
      if (frame_tick_reg) begin
        xlim_reg <= ball_xlim;  xinit_reg <= ball_xinit;
        ylim_reg <= ball_ylim;  yinit_reg <= ball_yinit;
        left_reg <= pad_left;   right_reg <= pad_right;
        top_reg  <= pad_top;    bottom_reg <= pad_bottom;
        ball_x_reg <= pend_x_reg;
        ball_y_reg <= pend_y_reg;
        frame_pending_reg <= 1'b1;
        if (frame_pending_reg) overrun_reg <= 1'b1;
      end
      if (wr_game_rst) begin
        pend_x_reg  <= ball_xinit; ball_x_reg <= ball_xinit;
        pend_y_reg  <= ball_yinit; ball_y_reg <= ball_yinit;
        overrun_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
    score_counter #(
      .SCORE_W   (SCORE_W),
      .WIN_SCORE (WIN_SCORE)
    ) u_score (
      .clock  (clock),
      .reset  (reset),
      .clear  (wr_game_rst),
      .inc    (score_inc && (inc_idx == 2'(gi))),
      .count  (scores[gi*SCORE_W +: SCORE_W]),
      .at_win (at_win[gi])
    );
  end

  // Increments stop once anyone wins, so at most one at_win flag is set.
  always_comb begin
    winner_code = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (at_win[p]) winner_code = WINNER_W'(p + 1);
    end
  end

  always_comb begin
    rdata_next = '0;
    case (bus.addr)
      ADDR_STATUS: rdata_next = status_word(winner_code, overrun_reg, frame_pending_reg);
      ADDR_BALL_X: rdata_next[0 +: X_W] = pend_x_reg;
      ADDR_BALL_Y: rdata_next[0 +: Y_W] = pend_y_reg;
      ADDR_LIMITS: begin
        rdata_next[0 +: X_W]           = xlim_reg;
        rdata_next[Y_FIELD_LSB +: Y_W] = ylim_reg;
      end
      ADDR_INIT: begin
        rdata_next[0 +: X_W]           = xinit_reg;
        rdata_next[Y_FIELD_LSB +: Y_W] = yinit_reg;
      end
      default: ;
    endcase
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (bus.addr == ADDR_PAD_BASE + ADDR_W'(2 * p)) begin
        rdata_next[0 +: X_W]           = left_reg[p*X_W +: X_W];
        rdata_next[Y_FIELD_LSB +: X_W] = right_reg[p*X_W +: X_W];
      end
      if (bus.addr == ADDR_PAD_BASE + ADDR_W'(2 * p + 1)) begin
        rdata_next[0 +: Y_W]           = top_reg[p*Y_W +: Y_W];
        rdata_next[Y_FIELD_LSB +: Y_W] = bottom_reg[p*Y_W +: Y_W];
      end
      if (bus.addr == ADDR_SCORE_BASE + ADDR_W'(p)) begin
        rdata_next[0 +: SCORE_W] = scores[p*SCORE_W +: SCORE_W];
      end
    end
  end

  assign bus.rdata = rdata_reg;
  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign winner    = winner_code;

endmodule

// File: doc/game_io_bank.md
GAME_IO_BANK -- requirements
Module: game_io_bank

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of paddles and score channels (legal range 2..4).
REQ-002 Parameter X_W, default 10: horizontal coordinate width.
REQ-003 Parameter Y_W, default 9: vertical coordinate width.
REQ-004 Parameter SCORE_W, default 4: per-player score width.
REQ-005 Parameter WIN_SCORE, default 7: score that ends the game (at most 2^SCORE_W-1).
REQ-006 Port list, one per line:
  clock  in  1  sole clock; all state changes on its rising edge.
  reset  in  1  synchronous, active-low reset.
  screen_end  in  1  level from the VGA timing block; high during blanking.
  wren  in  1  processor write strobe.
  addr  in  6  processor word address.
  wdata  in  32  processor write data.
  rdata  out  32  processor read data.
  ball_xlim, ball_xinit  in  X_W  ball x limit and x start position.
  ball_ylim, ball_yinit  in  Y_W  ball y limit and y start position.
  pad_left, pad_right  in  NUM_PLAYERS*X_W  packed paddle x bounds, player 0 in the LSBs.
  pad_top, pad_bottom  in  NUM_PLAYERS*Y_W  packed paddle y bounds.
  ball_x  out  X_W  committed ball x for display.
  ball_y  out  Y_W  committed ball y for display.
  winner  out  3  0 = none, p+1 = player p won.
  scores  out  NUM_PLAYERS*SCORE_W  packed scores.

Function
REQ-007 frame_tick SHALL be a one-cycle internal pulse on the cycle after screen_end is first sampled high following a low sample.
REQ-008 On frame_tick, all bound inputs SHALL be captured into shadow registers; processor reads SHALL return only shadow values.
REQ-009 On frame_tick, pending ball X/Y SHALL be copied to ball_x/ball_y (double buffering); ball_x/ball_y SHALL change at no other time except reset and GAME_RST.
REQ-010 On frame_tick, frame_pending SHALL set; if frame_pending is already set, overrun SHALL also set (sticky).
REQ-011 Address map (word addresses):
  0x00 STATUS: R {winner[4:2], overrun[1], frame_pending[0]}; W 1 to bit0/bit1 clears that bit.
  0x01 BALL_X RW pending x. 0x02 BALL_Y RW pending y.
  0x03 LIMITS R {ylim at [16+:Y_W], xlim at [0+:X_W]}. 0x04 INIT R, same packing.
  0x08+2p R {right, left}; 0x09+2p R {bottom, top}, same packing.
  0x05 SCORE_INC W: wdata[1:0] = player index. 0x06 GAME_RST W, data ignored.
  0x10+p SCORE_p R.
REQ-012 rdata SHALL be registered, valid one cycle after addr is presented; reads of unmapped addresses or p >= NUM_PLAYERS SHALL return 0.
REQ-013 Writes to read-only, unmapped, or out-of-range-player addresses SHALL be ignored.
REQ-014 BALL_X writes SHALL store min(wdata, xlim_shadow); BALL_Y writes SHALL store min(wdata, ylim_shadow), with the comparison done on the full 32-bit unsigned wdata.
REQ-015 SCORE_INC SHALL increment score p by 1 when winner == 0; the score reaching WIN_SCORE SHALL set winner = p+1 in the same cycle as the increment.
REQ-016 While winner != 0, SCORE_INC SHALL have no effect and winner SHALL hold.
REQ-017 GAME_RST SHALL clear scores, winner and overrun, and load pending and committed ball X/Y from ball_xinit/ball_yinit.
REQ-018 A STATUS clear coinciding with frame_tick: frame_pending SHALL remain set, and the overrun clear SHALL lose to an overrun set.
REQ-019 A BALL write coinciding with frame_tick: the commit SHALL use the old pending value, and the new value SHALL land in pending.
REQ-020 GAME_RST coinciding with frame_tick: GAME_RST values SHALL win for ball and scores, and frame_pending SHALL still set.

Reset
REQ-021 While reset == 0 at a clock edge: rdata = 0, scores = 0, winner = 0, frame_pending = 0, overrun = 0, shadows = 0, edge-detect history = 1 (no tick on the first cycle after reset), and pending/committed ball = ball_xinit/ball_yinit.
REQ-022 Reset SHALL take priority over every other event, including a transaction in progress.

Structure
REQ-023 Package game_io_pkg SHALL hold the address constants, STATUS bit positions, and the winner-code width.
REQ-024 One sub-module, score_counter (saturating SCORE_W counter with an at-WIN_SCORE flag), SHALL be instantiated NUM_PLAYERS times via generate.

Verification
REQ-025 Bench SHALL drive screen_end 0 then 1, with BALL_X pending = 100 -> ball_x = 100 exactly 2 cycles after screen_end rises, STATUS reads 0x1.
REQ-026 Bench SHALL send two frame_ticks without a clear -> STATUS = 0x3; write 0x3 -> STATUS = 0x0.
REQ-027 Bench SHALL set xlim shadow = 600 and write BALL_X = 700 -> BALL_X reads 600, and ball_x = 600 after the next tick.
REQ-028 Bench SHALL send SCORE_INC p=1 seven times -> SCORE_1 = 7 and winner = 2; an eighth increment SHALL leave both unchanged; GAME_RST SHALL return both to 0.
REQ-029 Bench SHALL issue a STATUS clear in the same cycle as frame_tick -> frame_pending remains 1.
REQ-030 Bench SHALL pulse reset low mid-game (score 3, winner 0) -> all outputs equal the REQ-021 values on the next cycle.
